// File: rtl/exu_oitf_pkg.sv
// ----------------------------------------------------------------------------
// exu_oitf_pkg
//   Shared constants for the outstanding-instruction track FIFO: register
//   index width, pc width and the default FIFO depth. Also provides the
//   derivation of the entry-index width from the depth.
// ----------------------------------------------------------------------------
package exu_oitf_pkg;

    localparam int RFIDX_WIDTH = 5;   // register file index width
    localparam int PC_SIZE     = 32;  // pc width carried for debug/commit
    localparam int OITF_DEPTH  = 2;   // default number of tracked entries

    // Entry index width: $clog2(depth), but never narrower than one bit so a
    // single-entry FIFO still has a legal pointer vector.
    function automatic int oitf_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : exu_oitf_pkg

// File: rtl/exu_oitf_if.sv
// ----------------------------------------------------------------------------
// exu_oitf_if
//   Bundles the dispatch, retire and hazard-check signals that connect the
//   EXU dispatch/writeback logic (master) to the OITF (slave).
//   Dispatch : dis_ena, dis_rdwen, dis_rdidx, dis_pc -> ; <- dis_ready, dis_ptr
//   Retire   : ret_ena -> ; <- ret_ptr, ret_rdwen, ret_rdidx, ret_pc
//   Check    : chk_rs{1,2}en/idx, chk_rdwen/idx -> ; <- match_rs1/rs2/rd
//   Status   : <- oitf_empty, oitf_full ; flush ->
// ----------------------------------------------------------------------------
interface exu_oitf_if
    import exu_oitf_pkg::*;
#(
    parameter int PTR_W   = 1,
    parameter int RFIDX_W = RFIDX_WIDTH,
    parameter int PC_W    = PC_SIZE
);
    logic               flush;

    logic               dis_ena;
    logic               dis_ready;
    logic [PTR_W-1:0]   dis_ptr;
    logic               dis_rdwen;
    logic [RFIDX_W-1:0] dis_rdidx;
    logic [PC_W-1:0]    dis_pc;

    logic               ret_ena;
    logic [PTR_W-1:0]   ret_ptr;
    logic               ret_rdwen;
    logic [RFIDX_W-1:0] ret_rdidx;
    logic [PC_W-1:0]    ret_pc;

    logic               chk_rs1en;
    logic               chk_rs2en;
    logic               chk_rdwen;
    logic [RFIDX_W-1:0] chk_rs1idx;
    logic [RFIDX_W-1:0] chk_rs2idx;
    logic [RFIDX_W-1:0] chk_rdidx;
    logic               match_rs1;
    logic               match_rs2;
    logic               match_rd;

    logic               oitf_empty;
    logic               oitf_full;

    // EXU side: dispatch, writeback and trap logic.
    modport master (
        output flush,
        output dis_ena, dis_rdwen, dis_rdidx, dis_pc,
        input  dis_ready, dis_ptr,
        output ret_ena,
        input  ret_ptr, ret_rdwen, ret_rdidx, ret_pc,
        output chk_rs1en, chk_rs2en, chk_rdwen, chk_rs1idx, chk_rs2idx, chk_rdidx,
        input  match_rs1, match_rs2, match_rd,
        input  oitf_empty, oitf_full
    );

    // OITF side.
    modport slave (
        input  flush,
        input  dis_ena, dis_rdwen, dis_rdidx, dis_pc,
        output dis_ready, dis_ptr,
        input  ret_ena,
        output ret_ptr, ret_rdwen, ret_rdidx, ret_pc,
        input  chk_rs1en, chk_rs2en, chk_rdwen, chk_rs1idx, chk_rs2idx, chk_rdidx,
        output match_rs1, match_rs2, match_rd,
        output oitf_empty, oitf_full
    );

endinterface : exu_oitf_if

// File: rtl/exu_oitf_gnrl_wrap_ptr.sv
// ----------------------------------------------------------------------------
// gnrl_wrap_ptr
//   Index counter running 0..DEPTH-1 with a wrap flag that toggles each time
//   the index rolls over. Comparing two such pointers (index and flag) tells
//   an empty FIFO from a full one without a separate occupancy counter.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset (index 0, flag 0)
//   clr  : synchronous clear to index 0, flag 0 (wins over inc)
//   inc  : advance by one entry
//   idx  : current entry index
//   flag : current wrap flag
// ----------------------------------------------------------------------------
module gnrl_wrap_ptr #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] idx,
    output logic             flag
);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx  <= '0;
            flag <= 1'b0;
        end else if (clr) begin
            idx  <= '0;
            flag <= 1'b0;
        end else if (inc) begin
            // Explicit rollover: DEPTH need not be a power of two.
            if (idx == LAST_IDX) begin
                idx  <= '0;
                flag <= ~flag;
            end else begin
                idx  <= idx + 1'b1;
            end
        end
    end

endmodule : gnrl_wrap_ptr

// File: rtl/exu_oitf.sv
// ----------------------------------------------------------------------------
// exu_oitf
//   Outstanding Instruction Track FIFO. Dispatch of a long-latency op
//   (LSU, MULDIV) allocates the tail entry; its writeback retires the head
//   entry. The rd of every live entry is compared against the operands of the
//   instruction at dispatch so dispatch can stall on RAW/WAW hazards.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset, drops all entries
//   oitf : exu_oitf_if.slave -- dispatch, retire, check and status signals
// ----------------------------------------------------------------------------
module exu_oitf
    import exu_oitf_pkg::*;
#(
    parameter int DEPTH   = OITF_DEPTH,
    parameter int PTR_W   = oitf_ptr_w(DEPTH),
    parameter int RFIDX_W = RFIDX_WIDTH,
    parameter int PC_W    = PC_SIZE
) (
    input  logic       clk,
    input  logic       rst,
    exu_oitf_if.slave  oitf
);

    logic [PTR_W-1:0]   wr_idx;
    logic               wr_flag;
    logic [PTR_W-1:0]   rd_idx;
    logic               rd_flag;
    logic               empty;
    logic               full;
    logic               alloc;
    logic               retire;

    logic [DEPTH-1:0]   ent_vld;
    logic [DEPTH-1:0]   ent_rdwen;
    logic [RFIDX_W-1:0] ent_rdidx [DEPTH];
    logic [PC_W-1:0]    ent_pc    [DEPTH];

    logic               hit_rs1;
    logic               hit_rs2;
    logic               hit_rd;

    // ------------------------------------------------------------------
    // Pointers and status. Both flags come only from registered pointers,
    // so dis_ready has no combinational path from ret_ena.
    // ------------------------------------------------------------------
    assign empty = (wr_idx == rd_idx) && (wr_flag == rd_flag);
    assign full  = (wr_idx == rd_idx) && (wr_flag != rd_flag);

    // flush overrides both handshakes; illegal requests (allocate when
    // full, retire when empty) are simply dropped.
    assign alloc  = oitf.dis_ena && !full  && !oitf.flush;
    assign retire = oitf.ret_ena && !empty && !oitf.flush;

    gnrl_wrap_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_wr_ptr (
        .clk  (clk),
        .rst  (rst),
        .clr  (oitf.flush),
        .inc  (alloc),
        .idx  (wr_idx),
        .flag (wr_flag)
    );

    gnrl_wrap_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_rd_ptr (
        .clk  (clk),
        .rst  (rst),
        .clr  (oitf.flush),
        .inc  (retire),
        .idx  (rd_idx),
        .flag (rd_flag)
    );

    assign oitf.oitf_empty = empty;
    assign oitf.oitf_full  = full;
    assign oitf.dis_ready  = !full;
    assign oitf.dis_ptr    = wr_idx;
    assign oitf.ret_ptr    = rd_idx;

    // ------------------------------------------------------------------
    // Entry valid bits: the only per-entry state that must reset, since
    // everything observable is qualified by it or by empty.
    // Allocate and retire never target the same index in one cycle: that
    // would need the FIFO to be both full and empty.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_vld <= '0;
        end else if (oitf.flush) begin
            ent_vld <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc && (wr_idx == PTR_W'(i))) begin
                    ent_vld[i] <= 1'b1;
                end else if (retire && (rd_idx == PTR_W'(i))) begin
                    ent_vld[i] <= 1'b0;
                end
            end
        end
    end

    // NOTE: the payload array has no reset; it is only ever read through
    // ent_vld or !empty, so resetting it would add reset fan-out for nothing.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc && (wr_idx == PTR_W'(i))) begin
                ent_rdwen[i] <= oitf.dis_rdwen;
                ent_rdidx[i] <= oitf.dis_rdidx;
                ent_pc[i]    <= oitf.dis_pc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Head entry view, forced to zero while nothing is live.
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default before the loop so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        oitf.ret_rdwen = 1'b0;
        oitf.ret_rdidx = '0;
        oitf.ret_pc    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!empty && (rd_idx == PTR_W'(i))) begin
                oitf.ret_rdwen = ent_rdwen[i];
                oitf.ret_rdidx = ent_rdidx[i];
                oitf.ret_pc    = ent_pc[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Hazard match: OR over live entries that write rd. An entry retiring
    // this cycle still matches (conservative); one allocating this cycle is
    // visible only once its valid bit is set.
    // ------------------------------------------------------------------
    always_comb begin
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        hit_rd  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && ent_rdwen[i]) begin
                hit_rs1 = hit_rs1 | (ent_rdidx[i] == oitf.chk_rs1idx);
                hit_rs2 = hit_rs2 | (ent_rdidx[i] == oitf.chk_rs2idx);
                hit_rd  = hit_rd  | (ent_rdidx[i] == oitf.chk_rdidx);
            end
        end
    end

    // x0 is hard-wired zero, so it never creates a dependency.
    assign oitf.match_rs1 = oitf.chk_rs1en && (oitf.chk_rs1idx != '0) && hit_rs1;
    assign oitf.match_rs2 = oitf.chk_rs2en && (oitf.chk_rs2idx != '0) && hit_rs2;
    assign oitf.match_rd  = oitf.chk_rdwen && (oitf.chk_rdidx  != '0) && hit_rd;

endmodule : exu_oitf

// File: tb/tb_exu_oitf.sv
// ----------------------------------------------------------------------------
// tb_exu_oitf
//   Drives a DEPTH=2 and a DEPTH=3 OITF from one shared stimulus set (sel
//   chooses which instance sees the handshakes). A queue-based model of the
//   outstanding ops predicts every output; it is compared each falling edge,
//   and hand-computed expectations pin the key scenarios.
// ----------------------------------------------------------------------------
module tb_exu_oitf;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sel = 1'b0;      // 0: DEPTH=2 instance, 1: DEPTH=3 instance

    always #5 clk = ~clk;

    // Shared stimulus
    logic        s_flush, s_dis_ena, s_dis_rdwen, s_ret_ena;
    logic [4:0]  s_dis_rdidx;
    logic [31:0] s_dis_pc;
    logic        s_rs1en, s_rs2en, s_rden;
    logic [4:0]  s_rs1, s_rs2, s_rd;

    exu_oitf_if #(.PTR_W(1), .RFIDX_W(5), .PC_W(32)) i2 ();
    exu_oitf_if #(.PTR_W(2), .RFIDX_W(5), .PC_W(32)) i3 ();

    assign i2.flush      = s_flush   & (sel == 1'b0);
    assign i2.dis_ena    = s_dis_ena & (sel == 1'b0);
    assign i2.ret_ena    = s_ret_ena & (sel == 1'b0);
    assign i3.flush      = s_flush   & (sel == 1'b1);
    assign i3.dis_ena    = s_dis_ena & (sel == 1'b1);
    assign i3.ret_ena    = s_ret_ena & (sel == 1'b1);
    assign i2.dis_rdwen  = s_dis_rdwen;
    assign i2.dis_rdidx  = s_dis_rdidx;
    assign i2.dis_pc     = s_dis_pc;
    assign i3.dis_rdwen  = s_dis_rdwen;
    assign i3.dis_rdidx  = s_dis_rdidx;
    assign i3.dis_pc     = s_dis_pc;
    assign i2.chk_rs1en  = s_rs1en;
    assign i2.chk_rs2en  = s_rs2en;
    assign i2.chk_rdwen  = s_rden;
    assign i2.chk_rs1idx = s_rs1;
    assign i2.chk_rs2idx = s_rs2;
    assign i2.chk_rdidx  = s_rd;
    assign i3.chk_rs1en  = s_rs1en;
    assign i3.chk_rs2en  = s_rs2en;
    assign i3.chk_rdwen  = s_rden;
    assign i3.chk_rs1idx = s_rs1;
    assign i3.chk_rs2idx = s_rs2;
    assign i3.chk_rdidx  = s_rd;

    exu_oitf #(.DEPTH(2)) u_dut2 (.clk(clk), .rst(rst), .oitf(i2.slave));
    exu_oitf #(.DEPTH(3)) u_dut3 (.clk(clk), .rst(rst), .oitf(i3.slave));

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: one ordered list of outstanding ops tagged with the instance
    // they belong to, plus allocation/retirement counts since the last
    // flush or reset (pointer = count mod depth).
    // ------------------------------------------------------------------
    typedef struct {
        int          d;
        bit          rdwen;
        logic [4:0]  rdidx;
        logic [31:0] pc;
    } ment_t;

    ment_t mq[$];
    int    ac[2];
    int    rc[2];

    function automatic int depth_of(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int live_count(input int d);
        int n = 0;
        foreach (mq[i]) if (mq[i].d == d) n++;
        return n;
    endfunction

    task automatic model_apply(input int d, input bit fl, input bit de, input bit re,
                               input bit rw, input logic [4:0] ri, input logic [31:0] pc);
        int    cnt;
        bit    a, r;
        ment_t e;
        cnt = live_count(d);
        if (fl) begin
            for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].d == d) mq.delete(i);
            ac[d] = 0;
            rc[d] = 0;
        end else begin
            a = de && (cnt < depth_of(d));
            r = re && (cnt > 0);
            if (r) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i].d == d) begin
                        mq.delete(i);
                        break;
                    end
                end
                rc[d]++;
            end
            if (a) begin
                e.d = d; e.rdwen = rw; e.rdidx = ri; e.pc = pc;
                mq.push_back(e);
                ac[d]++;
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            ac[0] = 0; ac[1] = 0;
            rc[0] = 0; rc[1] = 0;
        end else begin
            model_apply(0, i2.flush, i2.dis_ena, i2.ret_ena, i2.dis_rdwen, i2.dis_rdidx, i2.dis_pc);
            model_apply(1, i3.flush, i3.dis_ena, i3.ret_ena, i3.dis_rdwen, i3.dis_rdidx, i3.dis_pc);
        end
    end

    task automatic compare_dut(input int d);
        int          D, cnt;
        bit          hd, h1, h2, hr;
        logic [31:0] e_pc, e_idx, e_wen;
        logic [31:0] a[11];
        string       p;
        D   = depth_of(d);
        cnt = live_count(d);
        p   = $sformatf("d%0d", D);
        hd = 1'b0; h1 = 1'b0; h2 = 1'b0; hr = 1'b0;
        e_pc = '0; e_idx = '0; e_wen = '0;
        foreach (mq[i]) begin
            if (mq[i].d == d) begin
                if (!hd) begin
                    hd = 1'b1;
                    e_pc = mq[i].pc; e_idx = 32'(mq[i].rdidx); e_wen = 32'(mq[i].rdwen);
                end
                if (mq[i].rdwen && mq[i].rdidx == s_rs1) h1 = 1'b1;
                if (mq[i].rdwen && mq[i].rdidx == s_rs2) h2 = 1'b1;
                if (mq[i].rdwen && mq[i].rdidx == s_rd)  hr = 1'b1;
            end
        end
        if (d == 0) begin
            a = '{32'(i2.oitf_empty), 32'(i2.oitf_full), 32'(i2.dis_ready), 32'(i2.dis_ptr),
                  32'(i2.ret_ptr), 32'(i2.ret_rdwen), 32'(i2.ret_rdidx), i2.ret_pc,
                  32'(i2.match_rs1), 32'(i2.match_rs2), 32'(i2.match_rd)};
        end else begin
            a = '{32'(i3.oitf_empty), 32'(i3.oitf_full), 32'(i3.dis_ready), 32'(i3.dis_ptr),
                  32'(i3.ret_ptr), 32'(i3.ret_rdwen), 32'(i3.ret_rdidx), i3.ret_pc,
                  32'(i3.match_rs1), 32'(i3.match_rs2), 32'(i3.match_rd)};
        end
        check({p, ".empty"},     a[0], 32'(cnt == 0));
        check({p, ".full"},      a[1], 32'(cnt == D));
        check({p, ".dis_ready"}, a[2], 32'(cnt != D));
        check({p, ".dis_ptr"},   a[3], 32'(ac[d] % D));
        check({p, ".ret_ptr"},   a[4], 32'(rc[d] % D));
        check({p, ".ret_rdwen"}, a[5], e_wen);
        check({p, ".ret_rdidx"}, a[6], e_idx);
        check({p, ".ret_pc"},    a[7], e_pc);
        check({p, ".match_rs1"}, a[8],  32'(s_rs1en && s_rs1 != 0 && h1));
        check({p, ".match_rs2"}, a[9],  32'(s_rs2en && s_rs2 != 0 && h2));
        check({p, ".match_rd"},  a[10], 32'(s_rden  && s_rd  != 0 && hr));
    endtask

    always @(negedge clk) begin
        compare_dut(0);
        compare_dut(1);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at posedge+1)
    // ------------------------------------------------------------------
    task automatic step(input bit fl, input bit de, input bit rw, input logic [4:0] ri,
                        input logic [31:0] pc, input bit re);
        s_flush = fl; s_dis_ena = de; s_dis_rdwen = rw; s_dis_rdidx = ri; s_dis_pc = pc;
        s_ret_ena = re;
        @(posedge clk);
        #1;
        s_flush = 1'b0; s_dis_ena = 1'b0; s_ret_ena = 1'b0;
    endtask

    task automatic set_chk(input bit e1, input logic [4:0] r1, input bit e2, input logic [4:0] r2,
                           input bit er, input logic [4:0] rr);
        s_rs1en = e1; s_rs1 = r1; s_rs2en = e2; s_rs2 = r2; s_rden = er; s_rd = rr;
        #1;
    endtask

    initial begin
        s_flush = 0; s_dis_ena = 0; s_dis_rdwen = 0; s_ret_ena = 0;
        s_dis_rdidx = '0; s_dis_pc = '0;
        s_rs1en = 0; s_rs2en = 0; s_rden = 0; s_rs1 = '0; s_rs2 = '0; s_rd = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state
        check("rst.empty",     32'(i2.oitf_empty), 32'd1);
        check("rst.full",      32'(i2.oitf_full),  32'd0);
        check("rst.dis_ready", 32'(i2.dis_ready),  32'd1);
        check("rst.ret_rdidx", 32'(i2.ret_rdidx),  32'd0);

        // Fill DEPTH=2, then an ignored third allocate
        step(0, 1, 1, 5'd5, 32'h100, 0);
        step(0, 1, 1, 5'd6, 32'h104, 0);
        check("fill.full",      32'(i2.oitf_full), 32'd1);
        check("fill.dis_ready", 32'(i2.dis_ready), 32'd0);
        check("fill.ret_rdidx", 32'(i2.ret_rdidx), 32'd5);
        step(0, 1, 1, 5'd7, 32'h1ff, 0);
        check("ovf.ret_rdidx",  32'(i2.ret_rdidx), 32'd5);
        check("ovf.ret_pc",     i2.ret_pc,         32'h100);
        check("ovf.dis_ptr",    32'(i2.dis_ptr),   32'd0);

        // Hazard matching against live rd=x5, x6
        set_chk(1, 5'd5, 1, 5'd6, 1, 5'd6);
        check("haz.rs1_hit", 32'(i2.match_rs1), 32'd1);
        check("haz.rs2_hit", 32'(i2.match_rs2), 32'd1);
        check("haz.rd_hit",  32'(i2.match_rd),  32'd1);
        set_chk(1, 5'd0, 0, 5'd5, 0, 5'd6);
        check("haz.rs1_x0",  32'(i2.match_rs1), 32'd0);
        check("haz.rs2_dis", 32'(i2.match_rs2), 32'd0);
        check("haz.rd_dis",  32'(i2.match_rd),  32'd0);
        step(0, 0, 0, 5'd0, 32'h0, 1);
        step(0, 0, 0, 5'd0, 32'h0, 1);
        check("drain.empty", 32'(i2.oitf_empty), 32'd1);
        step(0, 1, 0, 5'd9, 32'h108, 0);      // entry that does not write rd
        set_chk(1, 5'd9, 0, 5'd0, 1, 5'd9);
        check("haz.nowen_rs1", 32'(i2.match_rs1), 32'd0);
        check("haz.nowen_rd",  32'(i2.match_rd),  32'd0);

        // Simultaneous allocate + retire at count 1
        step(0, 1, 1, 5'd10, 32'h10c, 1);
        check("sim.empty",     32'(i2.oitf_empty), 32'd0);
        check("sim.full",      32'(i2.oitf_full),  32'd0);
        check("sim.ret_rdidx", 32'(i2.ret_rdidx),  32'd10);
        check("sim.ret_ptr",   32'(i2.ret_ptr),    32'd1);
        check("sim.dis_ptr",   32'(i2.dis_ptr),    32'd0);

        // Flush with two live entries and same-cycle allocate/retire
        step(0, 1, 1, 5'd11, 32'h110, 0);
        check("pre_flush.full", 32'(i2.oitf_full), 32'd1);
        step(1, 1, 1, 5'd13, 32'h114, 1);
        check("flush.empty",     32'(i2.oitf_empty), 32'd1);
        check("flush.dis_ptr",   32'(i2.dis_ptr),    32'd0);
        check("flush.ret_ptr",   32'(i2.ret_ptr),    32'd0);
        check("flush.ret_rdidx", 32'(i2.ret_rdidx),  32'd0);
        set_chk(1, 5'd13, 1, 5'd11, 1, 5'd10);
        check("flush.rs1_gone", 32'(i2.match_rs1), 32'd0);
        check("flush.rs2_gone", 32'(i2.match_rs2), 32'd0);
        step(0, 1, 1, 5'd12, 32'h118, 0);
        check("post_flush.ret_rdidx", 32'(i2.ret_rdidx), 32'd12);
        check("post_flush.dis_ptr",   32'(i2.dis_ptr),   32'd1);

        // Reset asserted mid-cycle with a live hazard
        set_chk(1, 5'd12, 0, 5'd0, 0, 5'd0);
        check("mid.rs1_hit", 32'(i2.match_rs1), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst.empty",     32'(i2.oitf_empty), 32'd1);
        check("mid_rst.full",      32'(i2.oitf_full),  32'd0);
        check("mid_rst.dis_ready", 32'(i2.dis_ready),  32'd1);
        check("mid_rst.match_rs1", 32'(i2.match_rs1),  32'd0);
        check("mid_rst.dis_ptr",   32'(i2.dis_ptr),    32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        set_chk(0, 5'd0, 0, 5'd0, 0, 5'd0);

        // DEPTH=3 wrap: prefill two, then seven allocate/retire pairs
        sel = 1'b1;
        step(0, 1, 1, 5'd1, 32'h300, 0);
        step(0, 1, 1, 5'd2, 32'h304, 0);
        for (int k = 0; k < 7; k++) begin
            step(0, 1, 1, 5'(3 + k), 32'h308 + 32'(4 * k), 1);
            check($sformatf("wrap%0d.ret_pc", k),  i3.ret_pc,        32'h304 + 32'(4 * k));
            check($sformatf("wrap%0d.dis_ptr", k), 32'(i3.dis_ptr),  32'((3 + k) % 3));
            check($sformatf("wrap%0d.ret_ptr", k), 32'(i3.ret_ptr),  32'((1 + k) % 3));
            check($sformatf("wrap%0d.full", k),    32'(i3.oitf_full), 32'd0);
        end
        step(0, 1, 1, 5'd20, 32'h400, 0);
        check("d3.full",      32'(i3.oitf_full), 32'd1);
        check("d3.dis_ready", 32'(i3.dis_ready), 32'd0);
        // Allocate while full is dropped even though a retire fires
        step(0, 1, 1, 5'd21, 32'h404, 1);
        check("d3.full_ret.full",   32'(i3.oitf_full), 32'd0);
        check("d3.full_ret.ret_pc", i3.ret_pc,         32'h320);
        step(0, 0, 0, 5'd0, 32'h0, 1);
        check("d3.tail.ret_pc", i3.ret_pc, 32'h400);
        step(0, 0, 0, 5'd0, 32'h0, 1);
        check("d3.drain.empty", 32'(i3.oitf_empty), 32'd1);

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_exu_oitf
